// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: accepts RV32 instructions, drives the ALU control
// decoder, times the execute window and returns a result token. ALU_SEQ_PERF_EN adds perf counters.
module alu_op_sequencer #(
  parameter int EXEC_CYCLES = 1,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [1:0]         alu_op,
  output logic [9:0]         func_code,
  input  logic [3:0]         alu_ctrl,
  output logic               alu_en,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [3:0]         res_ctrl,
  output logic               res_illegal,
  output logic               busy,
  output logic [COUNT_W-1:0] op_count
`ifdef ALU_SEQ_PERF_EN
  ,
  output logic [COUNT_W-1:0] illegal_count,
  output logic [COUNT_W-1:0] stall_count
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] exec_cnt;
  logic       accept;
  logic       decode_illegal;
  logic       resp_done;

  // Only opcode, funct3 and funct7 steer the decoder; register and immediate fields are unused.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  function automatic logic [1:0] map_alu_op(input logic [6:0] opcode, input logic [2:0] funct3);
    if (opcode == 7'b0110011)
      return (funct3 == 3'b000 || funct3 == 3'b010) ? 2'b10 : 2'b01;
    if (opcode == 7'b0000011 || opcode == 7'b0100011)
      return 2'b00;
    return 2'b11;
  endfunction

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  assign instr_ready    = (state == IDLE);
  assign accept         = instr_valid && instr_ready;
  assign decode_illegal = (alu_op == 2'b11) || (alu_ctrl == 4'b1111);
  assign resp_done      = (state == RESP) && res_ready && !flush;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid) state_nxt = DECODE;
      DECODE:  state_nxt = decode_illegal ? RESP : EXEC;
      EXEC:    if (exec_cnt == 4'd1) state_nxt = RESP;
      RESP:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      alu_op      <= 2'b00;
      func_code   <= '0;
      alu_en      <= 1'b0;
      res_valid   <= 1'b0;
      res_ctrl    <= 4'b0000;
      res_illegal <= 1'b0;
      exec_cnt    <= '0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      if (accept && !flush) begin
        alu_op    <= map_alu_op(instr[6:0], instr[14:12]);
        func_code <= {instr[31:25], instr[14:12]};
      end
      if (flush) begin
        alu_en      <= 1'b0;
        res_valid   <= 1'b0;
        res_illegal <= 1'b0;
      end else begin
        case (state)
          DECODE: begin
            res_ctrl <= alu_ctrl;
            if (decode_illegal) begin
              res_illegal <= 1'b1;
              res_valid   <= 1'b1;
            end else begin
              res_illegal <= 1'b0;
              exec_cnt    <= EXEC_LOAD;
              alu_en      <= 1'b1;
            end
          end
          EXEC: begin
            if (exec_cnt == 4'd1) begin
              alu_en    <= 1'b0;
              res_valid <= 1'b1;
            end else begin
              exec_cnt <= exec_cnt - 4'd1;
            end
          end
          RESP: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              if (!res_illegal) op_count <= sat_inc(op_count);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef ALU_SEQ_PERF_EN
  // Flush does not clear these; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_count <= '0;
      stall_count   <= '0;
    end else begin
      if (resp_done && res_illegal) illegal_count <= sat_inc(illegal_count);
      if (res_valid && !res_ready)  stall_count   <= sat_inc(stall_count);
    end
  end
`else
  logic unused_resp_done;
  assign unused_resp_done = resp_done;
`endif

endmodule
